// File: rtl/frame_trig_ctrl.sv
// Frame counter on vsync falling edges plus CHANNELS programmable capture windows.
// Define FRAME_TRIG_REPEAT_EN to re-arm each window every PERIOD frames.
module frame_trig_ctrl #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned FW       = 32,
  parameter int unsigned LW       = 16,
  parameter int unsigned PERIOD   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vs,
  input  logic                   downloading,
  input  logic [CHANNELS-1:0]    enable,
  input  logic [CHANNELS*FW-1:0] start,
  input  logic [CHANNELS*LW-1:0] length,
  output logic [FW-1:0]          frame_cnt,
  output logic [CHANNELS-1:0]    active,
  output logic [CHANNELS-1:0]    on_pulse,
  output logic [CHANNELS-1:0]    off_pulse,
  output logic [CHANNELS-1:0]    done
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArmed  = 2'd1;
  localparam logic [1:0] StActive = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [FW-1:0] CntOne = FW'(1);
  localparam logic [LW-1:0] LenOne = LW'(1);

  logic          vs_q;
  logic          fe;
  logic [FW-1:0] cnt_q, cnt_d, cnt_inc;

  assign fe        = vs_q & ~vs;
  assign cnt_inc   = cnt_q + CntOne;
  assign frame_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (downloading) begin
      cnt_d = '0;
    end else if (fe) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      vs_q  <= vs;
      cnt_q <= cnt_d;
    end
  end

`ifndef FRAME_TRIG_REPEAT_EN
  // PERIOD only matters in the repeating build.
  if (PERIOD != 0) begin : g_period_unused
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]    st_q, st_d;
    logic [FW-1:0] tgt_q, tgt_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          on_q, on_d, off_q, off_d;
    logic [FW-1:0] ch_start;
    logic [LW-1:0] ch_len;
    logic          abort;
`ifdef FRAME_TRIG_REPEAT_EN
    logic          done_q, done_d;
`endif

    assign ch_start = start[i*FW +: FW];
    assign ch_len   = length[i*LW +: LW];
    // downloading outranks enable, which outranks a frame edge.
    assign abort    = downloading | ~enable[i];

    always_comb begin
      st_d  = st_q;
      tgt_d = tgt_q;
      rem_d = rem_q;
      on_d  = 1'b0;
      off_d = 1'b0;
`ifdef FRAME_TRIG_REPEAT_EN
      done_d = 1'b0;
`endif
      case (st_q)
        StIdle: begin
          if (enable[i] && !downloading) begin
            tgt_d = ch_start;
            if (ch_start == '0) begin
              st_d  = StActive;
              on_d  = 1'b1;
              rem_d = ch_len;
            end else begin
              st_d = StArmed;
            end
          end
        end
        StArmed: begin
          if (abort) begin
            st_d = StIdle;
          end else if (fe && (cnt_inc == tgt_q)) begin
            st_d  = StActive;
            on_d  = 1'b1;
            rem_d = ch_len;
          end
        end
        StActive: begin
          if (abort) begin
            st_d  = StIdle;
            off_d = 1'b1;
          end else if (fe) begin
            if (rem_q == LenOne) begin
              off_d = 1'b1;
              st_d  = StDone;
`ifdef FRAME_TRIG_REPEAT_EN
              if (PERIOD != 0) begin
                st_d   = StArmed;
                tgt_d  = tgt_q + FW'(PERIOD);
                done_d = 1'b1;
              end
`endif
            end else if (rem_q != '0) begin
              rem_d = rem_q - LenOne;
            end
          end
        end
        StDone: begin
          if (abort) begin
            st_d = StIdle;
          end
        end
        default: st_d = StIdle;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= StIdle;
        tgt_q <= '0;
        rem_q <= '0;
        on_q  <= 1'b0;
        off_q <= 1'b0;
`ifdef FRAME_TRIG_REPEAT_EN
        done_q <= 1'b0;
`endif
      end else begin
        st_q  <= st_d;
        tgt_q <= tgt_d;
        rem_q <= rem_d;
        on_q  <= on_d;
        off_q <= off_d;
`ifdef FRAME_TRIG_REPEAT_EN
        done_q <= done_d;
`endif
      end
    end

    assign active[i]    = (st_q == StActive);
    assign on_pulse[i]  = on_q;
    assign off_pulse[i] = off_q;
`ifdef FRAME_TRIG_REPEAT_EN
    assign done[i]      = (st_q == StDone) | done_q;
`else
    assign done[i]      = (st_q == StDone);
`endif
  end

endmodule

// File: tb/tb_frame_trig_ctrl.sv
// Directed bench for frame_trig_ctrl: table of frame-level steps plus wrap and repeat sequences.
module tb_frame_trig_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b1;
  logic        dl = 1'b0;
  logic [1:0]  en = 2'b00;
  logic [63:0] st = '0;
  logic [31:0] ln = '0;
  logic [31:0] cnt;
  logic [1:0]  act, onp, offp, dn;

  always #5 clk = ~clk;

  frame_trig_ctrl #(.CHANNELS(2), .FW(32), .LW(16), .PERIOD(0)) u_dut (
    .clk(clk), .rst(rst), .vs(vs), .downloading(dl), .enable(en), .start(st), .length(ln),
    .frame_cnt(cnt), .active(act), .on_pulse(onp), .off_pulse(offp), .done(dn)
  );

  // Narrow-counter instance for the wrap case.
  logic       vs4 = 1'b1;
  logic       dl4 = 1'b0;
  logic       en4 = 1'b0;
  logic [3:0] s4 = 4'd2;
  logic [3:0] l4 = 4'd2;
  logic [3:0] cnt4;
  logic       act4, on4, off4, dn4;

  frame_trig_ctrl #(.CHANNELS(1), .FW(4), .LW(4), .PERIOD(0)) u_dut4 (
    .clk(clk), .rst(rst), .vs(vs4), .downloading(dl4), .enable(en4), .start(s4), .length(l4),
    .frame_cnt(cnt4), .active(act4), .on_pulse(on4), .off_pulse(off4), .done(dn4)
  );

`ifdef FRAME_TRIG_REPEAT_EN
  logic       vsr = 1'b1;
  logic       dlr = 1'b0;
  logic       enr = 1'b0;
  logic [7:0] sr = 8'd4;
  logic [3:0] lr = 4'd2;
  logic [7:0] cntr;
  logic       actr, onr, offr, dnr;

  frame_trig_ctrl #(.CHANNELS(1), .FW(8), .LW(4), .PERIOD(8)) u_dutr (
    .clk(clk), .rst(rst), .vs(vsr), .downloading(dlr), .enable(enr), .start(sr), .length(lr),
    .frame_cnt(cntr), .active(actr), .on_pulse(onr), .off_pulse(offr), .done(dnr)
  );
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int nfe;
    int dl, en, s0, l0, s1, l1;
    int cnt, act, on, off, dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int nfe, int dl_v, int en_v, int s0, int l0, int s1, int l1,
                              int c, int a, int o, int f, int d);
    vec_t v;
    v.nfe = nfe; v.dl = dl_v; v.en = en_v;
    v.s0 = s0; v.l0 = l0; v.s1 = s1; v.l1 = l1;
    v.cnt = c; v.act = a; v.on = o; v.off = f; v.dn = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      vs = 1'b1; tick();
      vs = 1'b0; tick();
    end
  endtask

  task automatic frames4(input int n);
    for (int k = 0; k < n; k++) begin
      vs4 = 1'b1; tick();
      vs4 = 1'b0; tick();
    end
  endtask

`ifdef FRAME_TRIG_REPEAT_EN
  task automatic framesr(input int n);
    for (int k = 0; k < n; k++) begin
      vsr = 1'b1; tick();
      vsr = 1'b0; tick();
    end
  endtask
`endif

  initial begin
    //              nfe dl en  s0  l0  s1 l1  cnt act on off dn
    vecs.push_back(mk( 5, 0, 0,  0,  0,  0, 0,   5, 0, 0, 0, 0)); // 0 count 5
    vecs.push_back(mk( 3, 1, 0,  0,  0,  0, 0,   0, 0, 0, 0, 0)); // 1 downloading
    vecs.push_back(mk( 0, 0, 1, 10,  4,  0, 0,   0, 0, 0, 0, 0)); // 2 arm ch0
    vecs.push_back(mk( 9, 0, 1, 10,  4,  0, 0,   9, 0, 0, 0, 0)); // 3
    vecs.push_back(mk( 1, 0, 1, 10,  4,  0, 0,  10, 1, 1, 0, 0)); // 4 open fe10
    vecs.push_back(mk( 0, 0, 1, 10,  4,  0, 0,  10, 1, 0, 0, 0)); // 5
    vecs.push_back(mk( 3, 0, 1, 10,  4,  0, 0,  13, 1, 0, 0, 0)); // 6
    vecs.push_back(mk( 1, 0, 1, 10,  4,  0, 0,  14, 0, 0, 1, 1)); // 7 close fe14
    vecs.push_back(mk( 0, 0, 1, 10,  4,  0, 0,  14, 0, 0, 0, 1)); // 8
    vecs.push_back(mk( 2, 0, 1, 10,  4,  0, 0,  16, 0, 0, 0, 1)); // 9 done held
    vecs.push_back(mk( 0, 0, 0, 10,  4,  0, 0,  16, 0, 0, 0, 0)); // 10 disarm
    vecs.push_back(mk( 0, 1, 0,  0,  0,  3, 1,   0, 0, 0, 0, 0)); // 11 clear cnt
    vecs.push_back(mk( 0, 0, 3,  0,  0,  3, 1,   0, 1, 1, 0, 0)); // 12 ch0 start=0
    vecs.push_back(mk( 2, 0, 3,  0,  0,  3, 1,   2, 1, 0, 0, 0)); // 13
    vecs.push_back(mk( 1, 0, 3,  0,  0,  3, 1,   3, 3, 2, 0, 0)); // 14 ch1 open fe3
    vecs.push_back(mk( 1, 0, 3,  0,  0,  3, 1,   4, 1, 0, 2, 2)); // 15 ch1 close fe4
    vecs.push_back(mk(20, 0, 3,  0,  0,  3, 1,  24, 1, 0, 0, 2)); // 16 len0 stays open
    vecs.push_back(mk( 0, 0, 1,  0,  0,  3, 1,  24, 1, 0, 0, 0)); // 17 ch1 done->idle
    vecs.push_back(mk( 0, 0, 0,  0,  0,  3, 1,  24, 0, 0, 1, 0)); // 18 enable abort
    vecs.push_back(mk( 0, 1, 0,  0,  0,  0, 0,   0, 0, 0, 0, 0)); // 19
    vecs.push_back(mk( 0, 0, 3, 12,  5, 20, 2,   0, 0, 0, 0, 0)); // 20 arm both
    vecs.push_back(mk(12, 0, 3, 12,  5, 20, 2,  12, 1, 1, 0, 0)); // 21 ch0 open fe12
    vecs.push_back(mk( 0, 1, 3, 12,  5, 20, 2,   0, 0, 0, 1, 0)); // 22 download abort
    vecs.push_back(mk( 0, 0, 3, 12,  5, 20, 2,   0, 0, 0, 0, 0)); // 23 re-arm
    vecs.push_back(mk(12, 0, 3, 12,  5, 20, 2,  12, 1, 1, 0, 0)); // 24
    vecs.push_back(mk( 0, 0, 3, 99,  1, 20, 2,  12, 1, 0, 0, 0)); // 25 late change ignored
    vecs.push_back(mk( 4, 0, 3, 99,  1, 20, 2,  16, 1, 0, 0, 0)); // 26
    vecs.push_back(mk( 1, 0, 3, 99,  1, 20, 2,  17, 0, 0, 1, 1)); // 27 close fe17
    vecs.push_back(mk( 3, 0, 3, 99,  1, 20, 2,  20, 2, 2, 0, 1)); // 28 ch1 open fe20
    vecs.push_back(mk( 0, 0, 0, 99,  1, 20, 2,  20, 0, 0, 2, 0)); // 29 disarm both

    // Reset held while vsync toggles.
    for (int k = 0; k < 4; k++) begin
      vs = ~vs; vs4 = ~vs4;
      tick();
    end
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_act", 64'(act), 64'd0);
    check("rst_pulses", 64'({onp, offp, dn}), 64'd0);
    check("rst_cnt4", 64'(cnt4), 64'd0);
    vs = 1'b1; vs4 = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_cnt", 64'(cnt), 64'd0);
    check("post_rst_act", 64'(act), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      dl = 1'(vecs[i].dl);
      en = 2'(vecs[i].en);
      st = {32'(vecs[i].s1), 32'(vecs[i].s0)};
      ln = {16'(vecs[i].l1), 16'(vecs[i].l0)};
      if (vecs[i].nfe == 0) tick();
      else frames(vecs[i].nfe);
      check($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vecs[i].cnt));
      check($sformatf("v%0d_act", i), 64'(act), 64'(vecs[i].act));
      check($sformatf("v%0d_on", i), 64'(onp), 64'(vecs[i].on));
      check($sformatf("v%0d_off", i), 64'(offp), 64'(vecs[i].off));
      check($sformatf("v%0d_done", i), 64'(dn), 64'(vecs[i].dn));
    end

    // Wrap: arm at frame 5 for start 2, match only after 15->0->1->2.
    frames4(5);
    check("w_cnt5", 64'(cnt4), 64'd5);
    en4 = 1'b1;
    tick();
    check("w_armed_act", 64'(act4), 64'd0);
    frames4(12);
    check("w_cnt1", 64'(cnt4), 64'd1);
    check("w_not_yet", 64'(act4), 64'd0);
    frames4(1);
    check("w_cnt2", 64'(cnt4), 64'd2);
    check("w_on", 64'({act4, on4}), 64'b11);
    frames4(2);
    check("w_close", 64'({act4, off4, dn4}), 64'b011);
    check("w_cnt4", 64'(cnt4), 64'd4);

`ifdef FRAME_TRIG_REPEAT_EN
    enr = 1'b1;
    tick();
    for (int w = 0; w < 3; w++) begin
      framesr(w == 0 ? 4 : 6);
      check($sformatf("r%0d_open", w), 64'({actr, onr, dnr}), 64'b110);
      check($sformatf("r%0d_cnt", w), 64'(cntr), 64'(4 + 8 * w));
      framesr(1);
      check($sformatf("r%0d_mid", w), 64'({actr, onr, offr}), 64'b100);
      framesr(1);
      check($sformatf("r%0d_close", w), 64'({actr, offr, dnr}), 64'b011);
      tick();
      check($sformatf("r%0d_dpulse", w), 64'({actr, dnr}), 64'b00);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_trig_ctrl.md
Name: frame_trig_ctrl

Overview:
- Synthesizable, parametrised successor to the simulation dump-trigger logic.
- Counts video frames on the falling edge of vertical sync and holds the count at zero while ROM download is active.
- Drives CHANNELS independent capture windows, each with a programmable start frame and length.
- The testbench (dump on/off) and on-FPGA probes (signal-tap triggers, LED debug) consume the window and pulse outputs.

Parameters:
- CHANNELS, 2, number of independent trigger windows (1..8).
- FW, 32, frame counter width.
- LW, 16, window length width.
- PERIOD, 0, re-arm period in frames; used only when FRAME_TRIG_REPEAT_EN is defined; 0 means no re-arm.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- vs  in  1  vertical sync, already synchronous to clk; a frame edge is a 1->0 transition.
- downloading  in  1  ROM download in progress.
- enable  in  CHANNELS  per-channel arm request.
- start  in  CHANNELS*FW  per-channel start frame; channel i uses bits [i*FW +: FW].
- length  in  CHANNELS*LW  per-channel window length in frames; 0 means unbounded.
- frame_cnt  out  FW  current frame number.
- active  out  CHANNELS  window open.
- on_pulse  out  CHANNELS  one-cycle pulse when a window opens.
- off_pulse  out  CHANNELS  one-cycle pulse when a window closes.
- done  out  CHANNELS  window completed; held until the channel is disarmed.

Behaviour:
- Reset: all outputs 0, all channels IDLE, vs_l=1.
- Frame edge: fe = vs_l & ~vs, where vs_l is vs registered once.
- Frame counter:
  - While downloading=1: frame_cnt=0.
  - Otherwise it increments by 1 on each fe and wraps from all-ones to 0.
  - frame_cnt changes the cycle after fe.
- Per-channel FSM (IDLE, ARMED, ACTIVE, DONE), all registered:
  - IDLE: enable=1 & downloading=0 -> ARMED. If start=0, go directly to ACTIVE with on_pulse=1 in the same transition.
  - ARMED: fe with (frame_cnt+1)==start -> ACTIVE; on_pulse=1 for one cycle; remaining=length. Matching also works after counter wrap.
  - ACTIVE: active=1.
    - Each fe: remaining decrements.
    - On the fe where remaining==1: -> DONE with off_pulse=1. The window spans exactly length frame edges.
    - length=0: never closes on its own.
  - DONE: done=1, active=0. enable=0 -> IDLE.
- Disarm and abort:
  - enable=0 in ARMED or ACTIVE -> IDLE next cycle.
  - If the channel was ACTIVE, off_pulse=1 in that cycle.
  - downloading=1 forces every channel to IDLE next cycle. Channels that were ACTIVE emit off_pulse.
- Latency: on_pulse, active and off_pulse are registered one cycle after the causing fe or enable edge.
- Simultaneous events:
  - downloading outranks enable, and enable outranks fe.
  - A channel never asserts on_pulse and off_pulse in the same cycle, except the length==1 case: on_pulse at the opening fe, off_pulse at the next fe.
- start and length are sampled only on the IDLE->ARMED and ARMED->ACTIVE transitions. Changes after those transitions are ignored.

Optional Feature:
- Macro: FRAME_TRIG_REPEAT_EN.
- Defined, with PERIOD>0:
  - ACTIVE->DONE instead goes to ARMED.
  - The internal match target becomes previous target + PERIOD (mod 2^FW).
  - done pulses for one cycle on each completion instead of being held.
- Defined with PERIOD=0, or macro undefined: behaviour exactly as above. No PERIOD logic is synthesised when the macro is undefined.

Test Plan:
- Reset with vs toggling -> frame_cnt=0, active=0. After 5 frame edges with downloading=0, frame_cnt=5.
- downloading high for 3 frames, then low; ch0 start=10, length=4, enable=1 -> on_pulse at fe #10, active high for 4 frames, off_pulse at fe #14, done=1 until enable=0.
- ch0 start=0, length=0, ch1 start=3, length=1 -> ch0 active the cycle after arming and never closes. ch1 on_pulse at fe #3, off_pulse at fe #4.
- ch0 ACTIVE at frame 12, downloading asserted -> off_pulse next cycle, all channels IDLE, frame_cnt=0. Re-enable afterwards re-arms cleanly.
- FW=4, start=2, counter preloaded past 2 -> match occurs after the wrap 15->0->1->2.
- FRAME_TRIG_REPEAT_EN defined, PERIOD=8, start=4, length=2 -> windows at frames 4-5, 12-13, 20-21, with a one-cycle done pulse after each.
